// File: rtl/qtree_ingress_ctrl.sv
// qtree_ingress_ctrl: request FIFO, lookup issue and update-window arbiter.
// Ports: req_* in (FIFO push), lookup_* out (issue), host_* update window,
//   mm_ctrl_* out (table writes), res_valid_i/inflight_o/err_o accounting.
module qtree_ingress_ctrl #(
   parameter int KEY_WIDTH = 16,
   parameter int BYPASS_WIDTH = 1,
   parameter int MM_ADDR_WIDTH = 12,
   parameter int MM_DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 8,
   parameter int INFLIGHT_MAX = 32,
   localparam int INFLIGHT_WIDTH = $clog2(INFLIGHT_MAX + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [KEY_WIDTH-1:0]      req_data_i,
   input  logic [BYPASS_WIDTH-1:0]   req_bypass_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      host_upd_lock_i,
   output logic                      host_upd_grant_o,
   input  logic [MM_ADDR_WIDTH-1:0]  host_mm_addr_i,
   input  logic [MM_DATA_WIDTH-1:0]  host_mm_data_i,
   input  logic                      host_mm_write_i,
   output logic                      host_mm_ready_o,
   output logic [KEY_WIDTH-1:0]      lookup_data_o,
   output logic [BYPASS_WIDTH-1:0]   lookup_bypass_o,
   output logic                      lookup_valid_o,
   output logic [MM_ADDR_WIDTH-1:0]  mm_ctrl_addr_o,
   output logic [MM_DATA_WIDTH-1:0]  mm_ctrl_data_o,
   output logic                      mm_ctrl_write_o,
   input  logic                      res_valid_i,
   output logic [INFLIGHT_WIDTH-1:0] inflight_o,
   output logic                      err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = KEY_WIDTH + BYPASS_WIDTH;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_UPDATE
   } state_e;

   state_e state_q, state_d;

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             full, empty, push, issue;
   logic             res_ok, err_set, grant;

   assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = req_valid_i && !full;

   // Lock gates issue combinationally: a rising lock blocks the
   // transition edge, a falling lock allows issue on the very next edge.
   assign issue = !host_upd_lock_i && !empty
                  && (inflight_o < INFLIGHT_WIDTH'(INFLIGHT_MAX));

   // A result that coincides with an issue is always legal.
   assign res_ok  = res_valid_i && ((inflight_o != '0) || issue);
   assign err_set = res_valid_i && (inflight_o == '0) && !issue;

   assign req_ready_o      = !full;
   assign host_upd_grant_o = grant;
   assign host_mm_ready_o  = grant;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (host_upd_lock_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!host_upd_lock_i)         state_d = ST_RUN;
            else if (inflight_o == '0)    state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            grant = host_upd_lock_i;
            if (!host_upd_lock_i) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= {req_bypass_i, req_data_i};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
         if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, issue})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lookup_valid_o  <= 1'b0;
         lookup_data_o   <= '0;
         lookup_bypass_o <= '0;
      end else begin
         lookup_valid_o <= issue;
         if (issue) begin
            lookup_data_o   <= mem[rd_ptr_q][KEY_WIDTH-1:0];
            lookup_bypass_o <= mem[rd_ptr_q][ENT_W-1:KEY_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         inflight_o <= '0;
         err_o      <= 1'b0;
      end else begin
         case ({issue, res_ok})
            2'b10:   inflight_o <= inflight_o + 1'b1;
            2'b01:   inflight_o <= inflight_o - 1'b1;
            default: inflight_o <= inflight_o;
         endcase
         if (err_set) err_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mm_ctrl_write_o <= 1'b0;
         mm_ctrl_addr_o  <= '0;
         mm_ctrl_data_o  <= '0;
      end else begin
         mm_ctrl_write_o <= host_mm_write_i && grant;
         if (host_mm_write_i && grant) begin
            mm_ctrl_addr_o <= host_mm_addr_i;
            mm_ctrl_data_o <= host_mm_data_i;
         end
      end
   end

endmodule

// File: tb/tb_qtree_ingress_ctrl.sv
// tb_qtree_ingress_ctrl: directed stimulus with queued expectations
//   checked by a negedge monitor.
module tb_qtree_ingress_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [15:0] req_data_i;
   logic [0:0]  req_bypass_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        host_upd_lock_i;
   logic        host_upd_grant_o;
   logic [11:0] host_mm_addr_i;
   logic [63:0] host_mm_data_i;
   logic        host_mm_write_i;
   logic        host_mm_ready_o;
   logic [15:0] lookup_data_o;
   logic [0:0]  lookup_bypass_o;
   logic        lookup_valid_o;
   logic [11:0] mm_ctrl_addr_o;
   logic [63:0] mm_ctrl_data_o;
   logic        mm_ctrl_write_o;
   logic        res_valid_i;
   logic [5:0]  inflight_o;
   logic        err_o;

   always #5 clk = ~clk;

   qtree_ingress_ctrl dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .req_data_i(req_data_i),
      .req_bypass_i(req_bypass_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .host_upd_lock_i(host_upd_lock_i),
      .host_upd_grant_o(host_upd_grant_o),
      .host_mm_addr_i(host_mm_addr_i),
      .host_mm_data_i(host_mm_data_i),
      .host_mm_write_i(host_mm_write_i),
      .host_mm_ready_o(host_mm_ready_o),
      .lookup_data_o(lookup_data_o),
      .lookup_bypass_o(lookup_bypass_o),
      .lookup_valid_o(lookup_valid_o),
      .mm_ctrl_addr_o(mm_ctrl_addr_o),
      .mm_ctrl_data_o(mm_ctrl_data_o),
      .mm_ctrl_write_o(mm_ctrl_write_o),
      .res_valid_i(res_valid_i),
      .inflight_o(inflight_o),
      .err_o(err_o)
   );

   typedef struct packed {
      logic [15:0] key;
      logic        bp;
   } lk_t;

   typedef struct packed {
      logic [11:0] a;
      logic [63:0] d;
   } mm_t;

   lk_t lk_q[$];
   mm_t mm_q[$];
   lk_t e_lk;
   mm_t e_mm;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_issued = 0;
   int last_issue_cyc = -1;
   int last_mm_cyc = -1;
   int peak = 0;
   bit grant_seen = 1'b0;
   bit loop_en = 1'b0;
   logic man_res = 1'b0;
   logic [4:0] hist = '0;

   // Loopback returns each lookup's result a fixed delay after issue.
   assign res_valid_i = loop_en ? hist[4] : man_res;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_i && lookup_valid_o) begin
         n_issued++;
         last_issue_cyc = cyc;
         checks++;
         if (lk_q.size() == 0) begin
            errors++;
            $display("FAIL lookup_unexpected: got key=%h bp=%b, none expected",
                     lookup_data_o, lookup_bypass_o);
         end else begin
            e_lk = lk_q.pop_front();
            if ({lookup_data_o, lookup_bypass_o} !== {e_lk.key, e_lk.bp}) begin
               errors++;
               $display("FAIL lookup: got key=%h bp=%b expected key=%h bp=%b",
                        lookup_data_o, lookup_bypass_o, e_lk.key, e_lk.bp);
            end
         end
      end
      if (rst_i && mm_ctrl_write_o) begin
         last_mm_cyc = cyc;
         checks++;
         if (mm_q.size() == 0) begin
            errors++;
            $display("FAIL mm_unexpected: got addr=%h data=%h, none expected",
                     mm_ctrl_addr_o, mm_ctrl_data_o);
         end else begin
            e_mm = mm_q.pop_front();
            if ({mm_ctrl_addr_o, mm_ctrl_data_o} !== {e_mm.a, e_mm.d}) begin
               errors++;
               $display("FAIL mm: got addr=%h data=%h expected addr=%h data=%h",
                        mm_ctrl_addr_o, mm_ctrl_data_o, e_mm.a, e_mm.d);
            end
         end
      end
      if (int'(inflight_o) > peak) peak = int'(inflight_o);
      if (host_upd_grant_o) grant_seen = 1'b1;
      hist = {hist[3:0], lookup_valid_o};
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] k, input bit track);
      int w;
      logic [15:0] kk;
      w = 0;
      kk = k;
      while (!req_ready_o && w < 50) begin
         tick(1);
         w++;
      end
      if (!req_ready_o) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: ready=%b expected 1", req_ready_o);
      end
      req_data_i = kk;
      req_bypass_i = kk[0];
      req_valid_i = 1'b1;
      if (track) lk_q.push_back('{key: kk, bp: kk[0]});
      tick(1);
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (inflight_o != 0 && w < 100) begin
         man_res = 1'b1;
         tick(1);
         w++;
      end
      man_res = 1'b0;
      chk("drain_inflight", 64'(inflight_o), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready_o), 1);
      chk({tag, "_lk_valid"}, 64'(lookup_valid_o), 0);
      chk({tag, "_lk_data"}, 64'(lookup_data_o), 0);
      chk({tag, "_lk_bypass"}, 64'(lookup_bypass_o), 0);
      chk({tag, "_mm_write"}, 64'(mm_ctrl_write_o), 0);
      chk({tag, "_mm_addr"}, 64'(mm_ctrl_addr_o), 0);
      chk({tag, "_mm_data"}, mm_ctrl_data_o, 0);
      chk({tag, "_grant"}, 64'(host_upd_grant_o), 0);
      chk({tag, "_mm_ready"}, 64'(host_mm_ready_o), 0);
      chk({tag, "_inflight"}, 64'(inflight_o), 0);
      chk({tag, "_err"}, 64'(err_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nb;
      int c0;
      rst_i = 1'b0;
      req_data_i = '0;
      req_bypass_i = '0;
      req_valid_i = 1'b0;
      host_upd_lock_i = 1'b0;
      host_mm_addr_i = '0;
      host_mm_data_i = '0;
      host_mm_write_i = 1'b0;
      tick(3);
      check_reset_vals("rst0");
      rst_i = 1'b1;
      tick(2);

      // Three back-to-back lookups with results looped back.
      loop_en = 1'b1;
      peak = 0;
      push(16'h0001, 1'b1);
      push(16'h0002, 1'b1);
      push(16'h0003, 1'b1);
      tick(15);
      chk("t1_issued", 64'(n_issued), 3);
      chk("t1_peak", 64'(peak), 3);
      chk("t1_inflight", 64'(inflight_o), 0);
      chk("t1_err", 64'(err_o), 0);
      loop_en = 1'b0;

      // Fill the pipeline to its limit and then the FIFO.
      nb = n_issued;
      for (int i = 0; i < 40; i++) push(16'h1000 + 16'(i), 1'b1);
      tick(2);
      chk("t2_issued32", 64'(n_issued - nb), 32);
      chk("t2_inflight32", 64'(inflight_o), 32);
      chk("t2_ready_low", 64'(req_ready_o), 0);
      man_res = 1'b1;
      tick(8);
      man_res = 1'b0;
      tick(2);
      chk("t2_issued40", 64'(n_issued - nb), 40);
      chk("t2_inflight_back", 64'(inflight_o), 32);
      chk("t2_ready_high", 64'(req_ready_o), 1);
      drain();
      chk("t2_err", 64'(err_o), 0);

      // Update window with lookups outstanding.
      nb = n_issued;
      for (int i = 0; i < 4; i++) push(16'h0101 + 16'(i), 1'b1);
      tick(3);
      chk("t3_inflight4", 64'(inflight_o), 4);
      host_upd_lock_i = 1'b1;
      push(16'h0AAA, 1'b1);
      tick(3);
      chk("t3_no_issue", 64'(n_issued - nb), 4);
      chk("t3_grant_drain", 64'(host_upd_grant_o), 0);
      man_res = 1'b1;
      tick(4);
      man_res = 1'b0;
      chk("t3_grant_early", 64'(host_upd_grant_o), 0);
      tick(1);
      chk("t3_grant", 64'(host_upd_grant_o), 1);
      chk("t3_mm_ready", 64'(host_mm_ready_o), 1);
      for (int i = 0; i < 3; i++) begin
         host_mm_addr_i = 12'h100 + 12'(i);
         host_mm_data_i = {32'hCAFE0000 + 32'(i), 32'h12345678};
         host_mm_write_i = 1'b1;
         mm_q.push_back('{a: host_mm_addr_i, d: host_mm_data_i});
         tick(1);
      end
      host_mm_addr_i = 12'hFFF;
      host_mm_data_i = '1;
      host_upd_lock_i = 1'b0;
      tick(1);
      host_mm_write_i = 1'b0;
      tick(3);
      chk("t3_issued_after", 64'(n_issued - nb), 5);
      chk("t3_order", 64'(last_issue_cyc > last_mm_cyc), 1);
      drain();

      // Abandon the update while draining.
      grant_seen = 1'b0;
      push(16'h0201, 1'b1);
      push(16'h0202, 1'b1);
      tick(3);
      host_upd_lock_i = 1'b1;
      push(16'h0BBB, 1'b1);
      tick(1);
      host_mm_addr_i = 12'h0AB;
      host_mm_data_i = 64'hDEAD;
      host_mm_write_i = 1'b1;
      tick(1);
      host_mm_write_i = 1'b0;
      chk("t4_inflight2", 64'(inflight_o), 2);
      host_upd_lock_i = 1'b0;
      c0 = cyc;
      tick(2);
      chk("t4_resume_cyc", 64'(last_issue_cyc), 64'(c0 + 1));
      chk("t4_no_grant", 64'(grant_seen), 0);
      drain();

      // Stray result while idle.
      man_res = 1'b1;
      tick(1);
      man_res = 1'b0;
      tick(3);
      chk("t5_err", 64'(err_o), 1);
      chk("t5_inflight", 64'(inflight_o), 0);
      tick(5);
      chk("t5_err_sticky", 64'(err_o), 1);

      // Reset in the middle of an update window.
      host_upd_lock_i = 1'b1;
      tick(3);
      chk("t6_grant", 64'(host_upd_grant_o), 1);
      nb = n_issued;
      for (int i = 0; i < 5; i++) push(16'h0300 + 16'(i), 1'b0);
      chk("t6_inflight", 64'(inflight_o), 0);
      host_mm_addr_i = 12'h055;
      host_mm_data_i = 64'h55;
      host_mm_write_i = 1'b1;
      tick(1);
      host_mm_write_i = 1'b0;
      rst_i = 1'b0;
      #1;
      check_reset_vals("t6");
      host_upd_lock_i = 1'b0;
      tick(2);
      rst_i = 1'b1;
      tick(10);
      chk("t6_no_issue", 64'(n_issued - nb), 0);
      chk("t6_ready", 64'(req_ready_o), 1);

      chk("lk_q_empty", 64'(lk_q.size()), 0);
      chk("mm_q_empty", 64'(mm_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/qtree_ingress_ctrl.md
# qtree_ingress_ctrl

Upstream front end of the quadtree lookup pipeline: buffers lookup requests from the client in a small FIFO, issues them into the level pipeline one per cycle, and serialises table updates against lookups. When the host asks to update the tables, the block stops issuing and counts returning results until the pipeline is empty. It then grants the host exclusive use of the memory-mapped write port, so no lookup ever sees a half-updated set of level/match tables.

## Interface
Parameters:
- KEY_WIDTH, 16: lookup key width.
- BYPASS_WIDTH, 1: opaque per-request sideband width.
- MM_ADDR_WIDTH, 12: table write address width.
- MM_DATA_WIDTH, 64: table write data width.
- FIFO_DEPTH, 8: request FIFO entries; power of two, at least 2.
- INFLIGHT_MAX, 32: maximum lookups outstanding in the pipeline.
- INFLIGHT_WIDTH: derived, $clog2(INFLIGHT_MAX+1).

Ports:
- clk_i in 1: single clock; all logic is rising-edge.
- rst_i in 1: asynchronous, active-low reset.
- req_data_i in KEY_WIDTH: lookup key.
- req_bypass_i in BYPASS_WIDTH: sideband carried with the key.
- req_valid_i in 1: request valid.
- req_ready_o out 1: FIFO not full.
- host_upd_lock_i in 1: level signal; high requests an update window.
- host_upd_grant_o out 1: update window open.
- host_mm_addr_i in MM_ADDR_WIDTH: write address.
- host_mm_data_i in MM_DATA_WIDTH: write data.
- host_mm_write_i in 1: write strobe.
- host_mm_ready_o out 1: write accepted; equals host_upd_grant_o.
- lookup_data_o out KEY_WIDTH: key to the pipeline.
- lookup_bypass_o out BYPASS_WIDTH: sideband to the pipeline.
- lookup_valid_o out 1: issue pulse to the pipeline.
- mm_ctrl_addr_o out MM_ADDR_WIDTH: table write address to the pipeline.
- mm_ctrl_data_o out MM_DATA_WIDTH: table write data to the pipeline.
- mm_ctrl_write_o out 1: table write strobe to the pipeline.
- res_valid_i in 1: the pipeline's result-valid, used only for in-flight accounting.
- inflight_o out INFLIGHT_WIDTH: current number of outstanding lookups.
- err_o out 1: sticky accounting error.

## Operation
Request FIFO:
- Push when req_valid_i and req_ready_o are both high; req_ready_o = !full, in every FSM state.
- No fall-through: an entry written at edge N is first poppable at edge N+1.
- A push and a pop in the same cycle are both allowed.
- Pointers wrap modulo FIFO_DEPTH; full and empty are taken from a count, not from pointer equality.

Issue:
- In RUN, when the FIFO is not empty and inflight < INFLIGHT_MAX, pop the head.
- On the same edge, register lookup_data_o, lookup_bypass_o and lookup_valid_o=1.
- Otherwise lookup_valid_o=0; data and bypass hold their last values.

In-flight counter:
- +1 on each issue; -1 on each res_valid_i; both in the same cycle leave it unchanged.
- If res_valid_i arrives with the counter at 0 and no issue that cycle: counter stays 0 and err_o sets. err_o clears only on reset.

FSM states RUN, DRAIN, UPDATE:
- RUN -> DRAIN when host_upd_lock_i=1. No issue happens on the transition edge.
- DRAIN -> UPDATE when inflight==0 and lock is still high.
- DRAIN -> RUN if lock drops (the update is abandoned).
- UPDATE: host_upd_grant_o=1 and host_mm_ready_o=1. Each host write is registered one cycle later onto mm_ctrl_*_o, one write per cycle. Writes are ignored in every other state.
- UPDATE -> RUN when lock=0. A write strobed in that same cycle is dropped, because ready is evaluated combinationally from state and lock: ready = (state==UPDATE) && lock.

Ordering:
- The last write reaches mm_ctrl_write_o strictly before the first post-update lookup_valid_o.

## Timing
- All outputs are registered, except host_upd_grant_o and host_mm_ready_o, which are decoded from the state register and lock.
- Reset values: req_ready_o=1, lookup_valid_o=0, lookup_data_o=0, lookup_bypass_o=0, mm_ctrl_write_o=0, mm_ctrl_addr_o=0, mm_ctrl_data_o=0, host_upd_grant_o=0, host_mm_ready_o=0, inflight_o=0, err_o=0. FSM resets to RUN and the FIFO resets to empty.
- Asserting reset mid-operation discards FIFO contents, pending writes and the in-flight count.
- Request accepted at edge N with the FIFO empty -> lookup_valid_o high after edge N+1.
- Host write accepted at edge N -> mm_ctrl_write_o high for exactly one cycle after edge N.
- Lock rises, pipeline empty -> grant high 2 cycles later (RUN->DRAIN at the first edge, DRAIN->UPDATE at the second).
- Lock drops in UPDATE -> the first issue is possible at the next edge.
- Sustained throughput is 1 lookup per cycle in RUN.

## Test plan
- Reset, then push 3 keys 0x0001..0x0003 back-to-back with res_valid_i looped back 5 cycles after each issue -> three consecutive lookup_valid_o pulses in order; inflight_o peaks at 3 and returns to 0; err_o=0.
- Hold res_valid_i=0 and push 40 requests with INFLIGHT_MAX=32 -> exactly 32 issued; req_ready_o drops once 8 more are buffered; issue resumes one-for-one as res_valid_i pulses.
- Raise lock with 4 lookups in flight -> no issue while they are outstanding; grant rises 1 cycle after the 4th res_valid_i; 3 host writes appear on mm_ctrl_*_o unchanged, each 1 cycle late.
- Drop lock in DRAIN with 2 lookups still outstanding -> grant never asserts; issue resumes on the next edge; a host write strobed meanwhile produces no mm_ctrl_write_o.
- Pulse res_valid_i while idle -> err_o=1 and stays 1; inflight_o stays 0.
- Assert rst_i low mid-UPDATE with the FIFO holding 5 entries -> all outputs return to their reset values asynchronously; no lookups are issued after reset is released.
